// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder sequencer.
// With SERIAL_ADD_SUB_EN defined the bundle also carries the subtract select.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, sub, output busy, done, sum, carry_out);
`else
    modport master (output start, a, b, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, output busy, done, sum, carry_out);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-add slice, LSB first, one bit per clock.
// Optional macro SERIAL_ADD_SUB_EN adds a - b (B inverted, carry-in 1).
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last result
// RUN    | one operand bit per cycle, WIDTH cycles
// DONE   | one-cycle done pulse, result already on sum/carry_out
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sub;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_accept;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    // B is stored pre-inverted for subtract, so the slice itself is add-only
    assign w_s    = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_c    = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a  <= bus.a;
                        r_op_b  <= w_sub ? ~bus.b : bus.b;
                        r_carry <= w_sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    // Publish on entry to DONE so the result is valid with the done pulse
                    if (w_last) begin
                        r_sum  <= {w_s, r_res[WIDTH-1:1]};
                        r_cout <= w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic reference model plus directed cases.
module tb_serial_add_ctrl;
    localparam int W = 8;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic t_sub;
    int   checks;
    int   failures;
    bit   chk_en;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

`ifdef SERIAL_ADD_SUB_EN
    assign bus.sub = t_sub;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model_calc(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                              input logic ms);
        logic [W-1:0] bb;
        bb = ms ? ~mb : mb;
        return {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ms};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an accepted start makes the block busy for W+1 cycles, the last being done
    int           m_rem;
    logic [W:0]   m_pend;
    logic [W-1:0] m_sum;
    logic         m_cout;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_rem == 0) begin
            if (bus.start === 1'b1) begin
                m_pend = model_calc(bus.a, bus.b, SUB_EN ? t_sub : 1'b0);
                m_rem  = W + 1;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 1) {m_cout, m_sum} = m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model busy", bus.busy, m_rem > 0);
            check("model done", bus.done, m_rem == 1);
            check("model sum", bus.sum, m_sum);
            check("model carry_out", bus.carry_out, m_cout);
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input logic [W-1:0] es, input logic ec, input string nm);
        int n;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        t_sub     = ts;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        t_sub     = SUB_EN ? 1'($urandom) : 1'b0;
        check({nm, " busy after accept"}, bus.busy, 1);
        n = 1;
        while (bus.done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, n, W + 1);
        check({nm, " sum"}, bus.sum, es);
        check({nm, " carry_out"}, bus.carry_out, ec);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ndone;
        int last_done;
        checks    = 0;
        failures  = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        t_sub     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset sum", bus.sum, 0);
        check("reset carry_out", bus.carry_out, 0);
        rst = 1'b0;

        check("pin model FF+01", model_calc(8'hFF, 8'h01, 1'b0), 9'h100);
        check("pin model 10-01", model_calc(8'h10, 8'h01, 1'b1), 9'h10F);
        check("pin model 01-02", model_calc(8'h01, 8'h02, 1'b1), 9'h0FF);

        @(negedge clk);
        do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "35+4A");
        repeat (20) begin
            @(negedge clk);
            check("hold sum", bus.sum, 8'h7F);
            check("hold busy", bus.busy, 0);
        end
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "FF+01");
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "80+80");
        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "00+00");

        // start pulses during RUN and in the DONE cycle must be dropped
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; t_sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        n = 4;
        while (bus.done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ignored latency", n, W + 1);
        check("ignored sum", bus.sum, 8'h46);
        check("ignored carry_out", bus.carry_out, 0);
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        check("ignored no requeue", bus.busy, 0);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("ignored extra done", ndone, 0);

        // reset on the 4th RUN cycle
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort sum", bus.sum, 0);
        check("abort carry_out", bus.carry_out, 0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("abort no done", ndone, 0);
        do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "01+01 after abort");

        // start held high: one accept every W+2 cycles
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20;
        ndone = 0;
        last_done = -1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ndone++;
                check("b2b sum", bus.sum, 8'h30);
                if (last_done < 0) check("b2b first done", c, W + 1);
                else check("b2b spacing", c - last_done, W + 2);
                last_done = c;
            end
        end
        check("b2b done count", ndone, 4);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("b2b drain", bus.busy, 0);
        @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "10-01");
        do_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, "01-02");
        do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "01+02");
`endif

        // random traffic, checked cycle by cycle against the model
        for (int c = 0; c < 400; c++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            t_sub     = SUB_EN ? 1'($urandom) : 1'b0;
            rst       = ($urandom_range(0, 96) == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("final idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
